// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, opcode classes, ALU codes and PC-source selects shared by the multicycle controller.
package ctrl_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERROR
`ifdef CTRL_TRAP_EN
    , ST_TRAP
`endif
  } ctrlState_t;
  localparam int unsigned OP_R = 0;
  localparam int unsigned OP_ALUI = 1;
  localparam int unsigned OP_LD = 2;
  localparam int unsigned OP_ST = 3;
  localparam int unsigned OP_BEQ = 4;
  localparam int unsigned OP_J = 5;
  localparam int unsigned OP_PUSH = 6;
  localparam int unsigned OP_POP = 7;
  localparam int unsigned OP_HALT = 63;
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  // Non-R classes pick their ALU operation from the opcode alone.
  function automatic int unsigned aluOpFor(int unsigned opc);
    return opc == OP_BEQ ? ALU_SUB : ALU_ADD;
  endfunction
endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts consecutive memory-wait cycles and flags the last one before the timeout limit.
module ctrl_wait_timer #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic timeout
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
  logic [TIMEOUT_W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= (clear || !waiting) ? '0 : count + 1'b1;
  // The current wait cycle is the (2**TIMEOUT_W-1)th one; a ready this cycle wins because waiting drops.
  assign timeout = waiting && count == LAST;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout and SP push/pop.
// Defining CTRL_TRAP_EN adds a trap port/state for unknown opcodes instead of treating them as NOPs.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int FUNCT_W = 6,
  parameter int ALU_OP_W = 4,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                alu_zero,
  input  logic                im_ready,
  input  logic                dm_ready,
  output logic                im_read,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                dm_read,
  output logic                dm_write,
  output logic                mem_to_reg,
  output logic                sp_update,
  output logic                sp_dir,
  output logic                sp_addr,
  output logic                halted,
  output logic                busy,
  output logic                err
`ifdef CTRL_TRAP_EN
  , output logic              trap
`endif
);
`ifdef CTRL_TRAP_EN
  localparam ctrlState_t UNKNOWN_NEXT = ST_TRAP;
`else
  localparam ctrlState_t UNKNOWN_NEXT = ST_FETCH;
`endif
  ctrlState_t state, stateNext;
  logic [OPC_W-1:0] opReg;
  logic [FUNCT_W-1:0] functReg;
  logic waiting, timeout, clearWait, known;
  logic isR, isAluI, isLd, isSt, isBeq, isJ, isPush, isPop, memRead;
  assign isR = opReg == OPC_W'(OP_R);
  assign isAluI = opReg == OPC_W'(OP_ALUI);
  assign isLd = opReg == OPC_W'(OP_LD);
  assign isSt = opReg == OPC_W'(OP_ST);
  assign isBeq = opReg == OPC_W'(OP_BEQ);
  assign isJ = opReg == OPC_W'(OP_J);
  assign isPush = opReg == OPC_W'(OP_PUSH);
  assign isPop = opReg == OPC_W'(OP_POP);
  assign memRead = isLd || isPop;
  assign known = opcode <= OPC_W'(OP_POP);
  assign waiting = (state == ST_FETCH && !im_ready) || (state == ST_MEM && !dm_ready);
  assign clearWait = stateNext != state;
  ctrl_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) waitTimer (
    .clk(clk), .rst_n(rst_n), .waiting(waiting), .clear(clearWait), .timeout(timeout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      opReg <= '0;
      functReg <= '0;
    end else begin
      state <= stateNext;
      if (state == ST_DECODE) begin
        opReg <= opcode;
        functReg <= funct;
      end
    end
  always_comb begin
    stateNext = state;
    im_read = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_SEQ;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    alu_src = 1'b0;
    alu_op = '0;
    dm_read = 1'b0;
    dm_write = 1'b0;
    mem_to_reg = 1'b0;
    sp_update = 1'b0;
    sp_dir = 1'b0;
    sp_addr = 1'b0;
    halted = 1'b0;
    busy = 1'b0;
    err = 1'b0;
`ifdef CTRL_TRAP_EN
    trap = 1'b0;
`endif
    case (state)
      ST_IDLE: stateNext = start ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        busy = 1'b1;
        im_read = 1'b1;
        ir_write = im_ready;
        pc_write = im_ready;
        stateNext = im_ready ? ST_DECODE : timeout ? ST_ERROR : ST_FETCH;
      end
      ST_DECODE: begin
        busy = 1'b1;
        stateNext = opcode == OPC_W'(OP_HALT) ? ST_HALT : known ? ST_EXEC : UNKNOWN_NEXT;
      end
      ST_EXEC: begin
        busy = 1'b1;
        alu_src = isAluI || isLd || isSt;
        alu_op = isR ? ALU_OP_W'(functReg) : ALU_OP_W'(aluOpFor(32'(opReg)));
        pc_write = (isBeq && alu_zero) || isJ;
        pc_src = isBeq ? PC_BRANCH : isJ ? PC_JUMP : PC_SEQ;
        sp_update = isPush;
        stateNext = (isR || isAluI) ? ST_WB : (isLd || isSt || isPush || isPop) ? ST_MEM : ST_FETCH;
      end
      ST_MEM: begin
        busy = 1'b1;
        dm_read = memRead;
        dm_write = !memRead;
        sp_addr = isPush || isPop;
        stateNext = dm_ready ? (memRead ? ST_WB : ST_FETCH) : timeout ? ST_ERROR : ST_MEM;
      end
      ST_WB: begin
        busy = 1'b1;
        reg_write = 1'b1;
        reg_dst = isR;
        mem_to_reg = memRead;
        sp_update = isPop;
        sp_dir = isPop;
        stateNext = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        stateNext = start ? ST_FETCH : ST_HALT;
      end
      ST_ERROR: err = 1'b1;
`ifdef CTRL_TRAP_EN
      ST_TRAP: begin
        trap = 1'b1;
        stateNext = start ? ST_FETCH : ST_TRAP;
      end
`endif
      default: stateNext = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed instruction sequences; expected per-cycle outputs queued, checked by a monitor.
module tb_multicycle_ctrl_fsm;
  typedef struct packed {
    logic trap, im_read, ir_write, pc_write;
    logic [1:0] pc_src;
    logic reg_write, reg_dst, alu_src;
    logic [3:0] alu_op;
    logic dm_read, dm_write, mem_to_reg, sp_update, sp_dir, sp_addr, halted, busy, err;
  } outs_t;
  typedef struct {
    string name;
    outs_t v;
    outs_t m;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, alu_zero = 1'b0, im_ready = 1'b0, dm_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic im_read, ir_write, pc_write, reg_write, reg_dst, alu_src, dm_read, dm_write;
  logic mem_to_reg, sp_update, sp_dir, sp_addr, halted, busy, err, trapOut;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  outs_t actual;
  exp_t q[$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.OPC_W(6), .FUNCT_W(6), .ALU_OP_W(4), .TIMEOUT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .im_ready(im_ready), .dm_ready(dm_ready), .im_read(im_read), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src(alu_src), .alu_op(alu_op), .dm_read(dm_read), .dm_write(dm_write),
    .mem_to_reg(mem_to_reg), .sp_update(sp_update), .sp_dir(sp_dir), .sp_addr(sp_addr),
    .halted(halted), .busy(busy), .err(err)
`ifdef CTRL_TRAP_EN
    , .trap(trapOut)
`endif
  );
`ifndef CTRL_TRAP_EN
  assign trapOut = 1'b0;
`endif

  assign actual = {trapOut, im_read, ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src, alu_op,
                   dm_read, dm_write, mem_to_reg, sp_update, sp_dir, sp_addr, halted, busy, err};

  // Any cycle with a nonzero output word is a DUT response that must match the next queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (actual != '0) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected output: got %h, none expected", actual);
      end else begin
        x = q.pop_front();
        if (((actual ^ x.v) & x.m) != '0) begin
          miscompares++;
          $display("FAIL %s: got %h want %h", x.name, actual, x.v);
        end
      end
    end
  end

  function automatic outs_t base();
    outs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic want(string n, outs_t v, outs_t m = '1);
    exp_t x;
    x.name = n;
    x.v = v;
    x.m = m;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkZero(string n);
    vectors++;
    if (actual != '0) begin
      miscompares++;
      $display("FAIL %s: got %h want 0", n, actual);
    end
  endtask

  task automatic fetch(int waits, logic [5:0] opc, logic [5:0] fn);
    outs_t e;
    e = base();
    e.im_read = 1'b1;
    repeat (waits) begin
      want("fetch wait", e);
      cyc();
    end
    im_ready = 1'b1;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    want("fetch accept", e);
    cyc();
    im_ready = 1'b0;
    opcode = opc;
    funct = fn;
    want("decode", base());
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e, m;
    repeat (2) cyc();
    checkZero("reset state");
    rst_n = 1'b1;
    start = 1'b1;
    checkZero("idle with start");
    cyc();
    start = 1'b0;
    fetch(0, 6'd0, 6'd4);
    e = base(); e.alu_op = 4'd4;
    want("R exec", e); cyc();
    e = base(); e.reg_write = 1'b1; e.reg_dst = 1'b1;
    want("R wb", e); cyc();
    fetch(1, 6'd1, 6'd0);
    e = base(); e.alu_src = 1'b1;
    m = '1; m.alu_op = '0;
    want("ALUI exec", e, m); cyc();
    e = base(); e.reg_write = 1'b1;
    want("ALUI wb", e); cyc();
    fetch(0, 6'd2, 6'd0);
    e = base(); e.alu_src = 1'b1;
    want("LD exec", e); cyc();
    e = base(); e.dm_read = 1'b1;
    repeat (3) begin want("LD mem wait", e); cyc(); end
    dm_ready = 1'b1;
    want("LD mem done", e); cyc();
    dm_ready = 1'b0;
    e = base(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
    want("LD wb", e); cyc();
    fetch(0, 6'd3, 6'd0);
    e = base(); e.alu_src = 1'b1;
    want("ST exec", e); cyc();
    dm_ready = 1'b1;
    e = base(); e.dm_write = 1'b1;
    want("ST mem", e); cyc();
    dm_ready = 1'b0;
    fetch(0, 6'd4, 6'd0);
    alu_zero = 1'b1;
    start = 1'b1;
    e = base(); e.alu_op = 4'd1; e.pc_src = 2'd1; e.pc_write = 1'b1;
    want("BEQ taken exec", e); cyc();
    alu_zero = 1'b0;
    start = 1'b0;
    fetch(0, 6'd4, 6'd0);
    e = base(); e.alu_op = 4'd1; e.pc_src = 2'd1;
    want("BEQ not taken exec", e); cyc();
    fetch(0, 6'd5, 6'd0);
    e = base(); e.pc_write = 1'b1; e.pc_src = 2'd2;
    want("J exec", e); cyc();
    fetch(6, 6'd6, 6'd0);
    e = base(); e.sp_update = 1'b1;
    want("PUSH exec", e); cyc();
    e = base(); e.dm_write = 1'b1; e.sp_addr = 1'b1;
    want("PUSH mem wait", e); cyc();
    dm_ready = 1'b1;
    want("PUSH mem done", e); cyc();
    dm_ready = 1'b0;
    fetch(0, 6'd7, 6'd0);
    want("POP exec", base()); cyc();
    dm_ready = 1'b1;
    e = base(); e.dm_read = 1'b1; e.sp_addr = 1'b1;
    want("POP mem", e); cyc();
    dm_ready = 1'b0;
    e = base(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.sp_update = 1'b1; e.sp_dir = 1'b1;
    want("POP wb", e); cyc();
    fetch(0, 6'd9, 6'd0);
`ifdef CTRL_TRAP_EN
    e = '0; e.trap = 1'b1;
    want("trap hold", e); cyc();
    start = 1'b1;
    want("trap start", e); cyc();
    start = 1'b0;
`endif
    fetch(0, 6'd63, 6'd0);
    e = '0; e.halted = 1'b1;
    want("halt hold", e); cyc();
    start = 1'b1;
    want("halt start", e); cyc();
    start = 1'b0;
    fetch(0, 6'd2, 6'd0);
    e = base(); e.alu_src = 1'b1;
    want("LD2 exec", e); cyc();
    e = base(); e.dm_read = 1'b1;
    want("LD2 mem wait", e); cyc();
    rst_n = 1'b0;
    #2;
    checkZero("reset mid-mem");
    cyc();
    rst_n = 1'b1;
    start = 1'b1;
    checkZero("idle after reset");
    cyc();
    start = 1'b0;
    e = base(); e.im_read = 1'b1;
    repeat (7) begin want("fetch timeout wait", e); cyc(); end
    e = '0; e.err = 1'b1;
    start = 1'b1;
    want("error sticky", e); cyc();
    want("error ignores start", e); cyc();
    start = 1'b0;
    rst_n = 1'b0;
    #2;
    checkZero("reset clears error");
    cyc();
    rst_n = 1'b1;
    cyc();
    checkZero("idle final");
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised multicycle control FSM for the single-issue processor.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction class and drives datapath control strobes.
- Handles variable-latency instruction and data memories through ready handshakes, with a wait-timeout error.
- Adds reset, start/halt control and stack-pointer (push/pop) sequencing.

Parameters:
- OPC_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- ALU_OP_W, 4, ALU operation code width (must be <= FUNCT_W)
- TIMEOUT_W, 8, width of memory wait counter; timeout fires at 2**TIMEOUT_W-1 wait cycles

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE/HALT and begin fetching
- opcode  in  OPC_W  IR opcode field, valid from DECODE onward
- funct  in  FUNCT_W  IR funct field
- alu_zero  in  1  ALU zero flag, valid in EXEC
- im_ready  in  1  instruction memory data valid
- dm_ready  in  1  data memory access complete
- im_read  out  1  instruction fetch request
- ir_write  out  1  capture IR (im_ready accepted)
- pc_write  out  1  update PC
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
- reg_write  out  1  register file write
- reg_dst  out  1  1=rd, 0=rt
- alu_src  out  1  1=immediate, 0=register
- alu_op  out  ALU_OP_W  ALU operation
- dm_read, dm_write  out  1 each  data memory strobes
- mem_to_reg  out  1  writeback source is memory
- sp_update  out  1  SP write
- sp_dir  out  1  0=decrement, 1=increment
- sp_addr  out  1  data memory address taken from SP
- halted, busy, err  out  1 each  status

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0; wait counter 0; latched opcode/funct 0. Reset mid-access abandons the transaction immediately.
- Constants (package): R=0, ALUI=1, LD=2, ST=3, BEQ=4, J=5, PUSH=6, POP=7, HALT=63.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- IDLE: busy=0. start=1 -> FETCH.
- FETCH:
  - im_read=1 and busy=1 held until im_ready=1.
  - ir_write=1 and pc_write=1 with pc_src=0 are Mealy on im_ready in that cycle; state -> DECODE.
- DECODE: latch opcode/funct. HALT -> HALT. Unknown opcode -> FETCH (NOP). Otherwise -> EXEC.
- EXEC, registered controls by class:
  - R: alu_src=0, alu_op=funct[ALU_OP_W-1:0] -> WB.
  - ALUI: alu_src=1, alu_op=opcode-mapped -> WB.
  - LD/ST: alu_src=1, alu_op=ADD(0) -> MEM.
  - BEQ: alu_op=SUB(1); pc_write=alu_zero, pc_src=1 -> FETCH.
  - J: pc_write=1, pc_src=2 -> FETCH.
  - PUSH: sp_update=1, sp_dir=0 -> MEM.
  - POP: -> MEM.
- MEM:
  - LD/POP: dm_read=1 held until dm_ready. POP also asserts sp_addr.
  - ST/PUSH: dm_write=1 held until dm_ready. PUSH also asserts sp_addr.
  - On dm_ready: ST/PUSH -> FETCH; LD/POP -> WB.
- WB:
  - reg_write=1 for exactly one cycle; reg_dst=1 for R, else 0.
  - mem_to_reg=1 for LD/POP.
  - POP also asserts sp_update=1, sp_dir=1.
  - -> FETCH.
- Zero-wait latencies: R/ALUI 4 cycles, LD/POP 5, ST/PUSH 4, BEQ/J 3.
- Wait counter:
  - Increments each cycle in FETCH or MEM while the relevant ready is 0; clears on ready or state change.
  - Reaching 2**TIMEOUT_W-1 -> ERROR (err=1, all strobes 0). ERROR is sticky until reset; start is ignored.
  - A ready arriving in the same cycle as the limit takes priority: no error.
- HALT: halted=1, busy=0. start -> FETCH, clearing halted on the transition.
- start is ignored in every state except IDLE/HALT.
- Strobes are never asserted simultaneously: no dm_read with dm_write, no reg_write outside WB.

Optional Feature:
- Macro: CTRL_TRAP_EN.
- Defined:
  - Adds output trap (1 bit) and state TRAP.
  - An unknown opcode in DECODE -> TRAP with trap=1, sticky until start, then -> FETCH.
- Undefined: unknown opcodes execute as NOP (DECODE -> FETCH); the trap port is absent.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALU_ADD/ALU_SUB codes;
  - pc_src encodings.
- One sub-module, ctrl_wait_timer (parametrised TIMEOUT_W), provides the counter and its timeout flag.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset mid-MEM with dm_read=1, rst_n low -> all outputs 0 in the same cycle, state IDLE; start -> im_read=1 next cycle.
- R-type opcode=0, funct=4, zero-wait memory -> alu_op=4 in EXEC, reg_write=1 and reg_dst=1 in cycle 4, FETCH in cycle 5.
- LD with dm_ready delayed 3 cycles -> dm_read high exactly 4 cycles, then mem_to_reg=1 and reg_write=1 for one cycle.
- BEQ with alu_zero=1 -> pc_write=1, pc_src=1 in EXEC; with alu_zero=0 -> pc_write=0; 3-cycle latency.
- PUSH then POP -> PUSH: sp_update=1/sp_dir=0 in EXEC, then dm_write with sp_addr=1. POP: dm_read with sp_addr=1, then WB with sp_update=1/sp_dir=1.
- Timeout and halt:
  - TIMEOUT_W=3, im_ready held 0 -> err=1 after 7 wait cycles; start ignored.
  - Separate run: HALT opcode -> halted=1; start -> FETCH.
